// File: rtl/instr_fetch_reg.sv
// Instruction fetch register: issues one memory read per accepted fetch
// request, captures the returned word into the instruction register and
// exposes its decoded instruction fields combinationally.
// Optional feature macro: FETCH_TIMEOUT_EN adds a REQ-cycle watchdog that
// aborts a fetch after TIMEOUT_CYCLES cycles without mem_ready and raises
// the sticky fetch_err flag. Without it, REQ waits indefinitely.
module instr_fetch_reg #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic [31:0] pc_in,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir_out,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr,
    output logic [31:0] pc_plus4,
    output logic        ir_valid,
    output logic        busy,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_mem_addr;
    logic        r_mem_rd;
    logic [31:0] r_ir_out;
    logic        r_ir_valid;
    logic        r_busy;

`ifdef FETCH_TIMEOUT_EN
    // Counter just wide enough to hold TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_fetch_err;
`else
    // The timeout length only matters when the watchdog is built.
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES;
`endif

    // Fetch control FSM; every externally visible control bit is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_mem_addr <= 32'd0;
            r_mem_rd   <= 1'b0;
            r_ir_out   <= 32'd0;
            r_ir_valid <= 1'b0;
            r_busy     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_fetch_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (fetch_start) begin
                        r_mem_addr <= pc_in;
                        r_mem_rd   <= 1'b1;
                        r_ir_valid <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_REQ;
`ifdef FETCH_TIMEOUT_EN
                        r_to_cnt    <= '0;
                        r_fetch_err <= 1'b0;
`endif
                    end else begin
                        // DONE lasts a single cycle; ir_out/ir_valid hold.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_REQ: begin
                    // fetch_start is deliberately not looked at here.
                    if (mem_ready) begin
                        // Data arriving on the timeout cycle still completes.
                        r_ir_out   <= mem_rdata;
                        r_mem_rd   <= 1'b0;
                        r_ir_valid <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_DONE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (r_to_cnt == CNT_LAST) begin
                        // Abort: instruction register and ir_valid untouched.
                        r_mem_rd    <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_rd <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_rd   = r_mem_rd;
    assign ir_out   = r_ir_out;
    assign ir_valid = r_ir_valid;
    assign busy     = r_busy;

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = r_fetch_err;
`else
    assign fetch_err = 1'b0;
`endif

    // Sequential address of the latched fetch, wrapping at 2^32.
    assign pc_plus4 = r_mem_addr + 32'd4;

    // Field decode: pure slices of the instruction register, no extra latency.
    assign opcode = r_ir_out[31:26];
    assign rs     = r_ir_out[25:21];
    assign rt     = r_ir_out[20:16];
    assign rd     = r_ir_out[15:11];
    assign shamt  = r_ir_out[10:6];
    assign funct  = r_ir_out[5:0];
    assign imm16  = r_ir_out[15:0];
    assign jaddr  = r_ir_out[25:0];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Self-checking bench for instr_fetch_reg: table of directed fetches plus
// hand-written sequences for stalls, reset abort, back-to-back and timeout.
module tb_instr_fetch_reg;

    logic        clk;
    logic        reset;
    logic        fetch_start;
    logic [31:0] pc_in;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] ir_out;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic [31:0] pc_plus4;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;

    int n_checks = 0;
    int n_errs   = 0;

    instr_fetch_reg #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_in(pc_in),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .ir_out(ir_out), .opcode(opcode), .rs(rs),
        .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
        .jaddr(jaddr), .pc_plus4(pc_plus4), .ir_valid(ir_valid), .busy(busy),
        .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp_pc4;
        logic [5:0]  op;
        logic [4:0]  f_rs;
        logic [4:0]  f_rt;
        logic [4:0]  f_rd;
        logic [4:0]  f_sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] ja;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_err0(input string nm);
`ifndef FETCH_TIMEOUT_EN
        chk(nm, 32'(fetch_err), 32'd0);
`endif
    endtask

    initial begin
        int errs_before;
        logic [31:0] prev_ir;

        vecs[0] = '{32'h0040_0000, 32'h8C8A_0004, 0, 32'h0040_0004,
                    6'h23, 5'd4, 5'd10, 5'd0, 5'd0, 6'h04, 16'h0004, 26'h08A_0004};
        vecs[1] = '{32'hFFFF_FFFC, 32'h3C01_FFFF, 2, 32'h0000_0000,
                    6'h0F, 5'd0, 5'd1, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h001_FFFF};
        vecs[2] = '{32'h0000_1000, 32'h0022_1820, 1, 32'h0000_1004,
                    6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h1820, 26'h022_1820};
        vecs[3] = '{32'h1234_5678, 32'h0009_4100, 3, 32'h1234_567C,
                    6'h00, 5'd0, 5'd9, 5'd8, 5'd4, 6'h00, 16'h4100, 26'h009_4100};
        vecs[4] = '{32'h8000_0000, 32'h0BFF_FFFF, 0, 32'h8000_0004,
                    6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FF_FFFF};

        reset = 1'b1; fetch_start = 1'b0; pc_in = 32'd0;
        mem_ready = 1'b0; mem_rdata = 32'd0;
        @(negedge clk);
        step();
        // Reset state
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_ir_out", ir_out, 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_pc_plus4", pc_plus4, 32'd4);
        $display("reset: mem_rd=%0d ir_out=0x%08h busy=%0d", mem_rd, ir_out, busy);
        reset = 1'b0;
        step();

        // Table-driven fetches with varying memory latency
        for (int v = 0; v < 5; v++) begin
            errs_before = n_errs;
            fetch_start = 1'b1; pc_in = vecs[v].pc;
            step();
            fetch_start = 1'b0; pc_in = 32'hA5A5_A5A5;
            chk($sformatf("v%0d_mem_rd_start", v), 32'(mem_rd), 32'd1);
            chk($sformatf("v%0d_busy_start", v), 32'(busy), 32'd1);
            chk($sformatf("v%0d_ir_valid_start", v), 32'(ir_valid), 32'd0);
            chk($sformatf("v%0d_mem_addr", v), mem_addr, vecs[v].pc);
            for (int d = 0; d < vecs[v].delay; d++) begin
                step();
                chk($sformatf("v%0d_mem_rd_wait%0d", v, d), 32'(mem_rd), 32'd1);
            end
            mem_ready = 1'b1; mem_rdata = vecs[v].rdata;
            step();
            mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
            chk($sformatf("v%0d_ir_valid", v), 32'(ir_valid), 32'd1);
            chk($sformatf("v%0d_ir_out", v), ir_out, vecs[v].rdata);
            chk($sformatf("v%0d_mem_rd_done", v), 32'(mem_rd), 32'd0);
            chk($sformatf("v%0d_busy_done", v), 32'(busy), 32'd0);
            chk($sformatf("v%0d_pc_plus4", v), pc_plus4, vecs[v].exp_pc4);
            chk($sformatf("v%0d_opcode", v), 32'(opcode), 32'(vecs[v].op));
            chk($sformatf("v%0d_rs", v), 32'(rs), 32'(vecs[v].f_rs));
            chk($sformatf("v%0d_rt", v), 32'(rt), 32'(vecs[v].f_rt));
            chk($sformatf("v%0d_rd", v), 32'(rd), 32'(vecs[v].f_rd));
            chk($sformatf("v%0d_shamt", v), 32'(shamt), 32'(vecs[v].f_sh));
            chk($sformatf("v%0d_funct", v), 32'(funct), 32'(vecs[v].fn));
            chk($sformatf("v%0d_imm16", v), 32'(imm16), 32'(vecs[v].imm));
            chk($sformatf("v%0d_jaddr", v), 32'(jaddr), 32'(vecs[v].ja));
            chk_err0($sformatf("v%0d_fetch_err", v));
            step();
            chk($sformatf("v%0d_ir_valid_hold", v), 32'(ir_valid), 32'd1);
            chk($sformatf("v%0d_busy_idle", v), 32'(busy), 32'd0);
            $display("vec %0d: pc=0x%08h delay=%0d ir_out=0x%08h pc_plus4=0x%08h errs=%0d",
                     v, vecs[v].pc, vecs[v].delay, ir_out, pc_plus4, n_errs - errs_before);
        end

        // mem_ready while idle is ignored
        prev_ir = ir_out;
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_ready = 1'b0;
        chk("idle_ready_ir_out", ir_out, prev_ir);
        chk("idle_ready_ir_valid", 32'(ir_valid), 32'd1);
        $display("idle mem_ready: ir_out=0x%08h", ir_out);

        // Five-cycle stall with a second start pulse that must be ignored
        fetch_start = 1'b1; pc_in = 32'h0000_0100;
        step();
        fetch_start = 1'b0;
        chk("stall_mem_rd_0", 32'(mem_rd), 32'd1);
        for (int d = 0; d < 5; d++) begin
            if (d == 1) begin fetch_start = 1'b1; pc_in = 32'hDEAD_0000; end
            else fetch_start = 1'b0;
            step();
            chk($sformatf("stall_mem_rd_%0d", d + 1), 32'(mem_rd), 32'd1);
            chk($sformatf("stall_busy_%0d", d + 1), 32'(busy), 32'd1);
            chk($sformatf("stall_mem_addr_%0d", d + 1), mem_addr, 32'h0000_0100);
        end
        fetch_start = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h2442_0001;
        step();
        mem_ready = 1'b0;
        chk("stall_ir_out", ir_out, 32'h2442_0001);
        chk("stall_opcode", 32'(opcode), 32'h09);
        chk("stall_mem_addr_done", mem_addr, 32'h0000_0100);
        step();
        chk("stall_no_refetch_rd", 32'(mem_rd), 32'd0);
        chk("stall_no_refetch_busy", 32'(busy), 32'd0);
        $display("stall: mem_addr=0x%08h ir_out=0x%08h", mem_addr, ir_out);

        // Reset in the second REQ cycle aborts the fetch
        fetch_start = 1'b1; pc_in = 32'h0000_0200;
        step();
        fetch_start = 1'b0;
        step();
        chk("rstreq_mem_rd_before", 32'(mem_rd), 32'd1);
        reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D; fetch_start = 1'b1;
        step();
        reset = 1'b0; mem_ready = 1'b0; fetch_start = 1'b0;
        chk("rstreq_mem_rd", 32'(mem_rd), 32'd0);
        chk("rstreq_ir_out", ir_out, 32'd0);
        chk("rstreq_ir_valid", 32'(ir_valid), 32'd0);
        chk("rstreq_busy", 32'(busy), 32'd0);
        chk("rstreq_mem_addr", mem_addr, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ready = 1'b0;
        chk("rstreq_late_ready_ir", ir_out, 32'd0);
        chk("rstreq_late_ready_valid", 32'(ir_valid), 32'd0);
        $display("reset in REQ: mem_rd=%0d ir_out=0x%08h", mem_rd, ir_out);

        // Back-to-back: fetch_start held high through DONE
        fetch_start = 1'b1; pc_in = 32'h0000_0300;
        step();
        mem_ready = 1'b1; mem_rdata = 32'hAAAA_0001; pc_in = 32'h0000_0304;
        step();
        mem_ready = 1'b0;
        chk("b2b_done_valid", 32'(ir_valid), 32'd1);
        chk("b2b_done_ir", ir_out, 32'hAAAA_0001);
        chk("b2b_done_busy", 32'(busy), 32'd0);
        step();
        fetch_start = 1'b0;
        chk("b2b_req2_busy", 32'(busy), 32'd1);
        chk("b2b_req2_valid", 32'(ir_valid), 32'd0);
        chk("b2b_req2_addr", mem_addr, 32'h0000_0304);
        chk("b2b_req2_rd", 32'(mem_rd), 32'd1);
        chk("b2b_req2_ir_hold", ir_out, 32'hAAAA_0001);
        mem_ready = 1'b1; mem_rdata = 32'hBBBB_0002;
        step();
        mem_ready = 1'b0;
        chk("b2b_done2_ir", ir_out, 32'hBBBB_0002);
        chk("b2b_done2_pc4", pc_plus4, 32'h0000_0308);
        chk_err0("b2b_fetch_err");
        step();
        $display("back-to-back: ir_out=0x%08h mem_addr=0x%08h", ir_out, mem_addr);

`ifdef FETCH_TIMEOUT_EN
        // Watchdog abort after 16 REQ cycles without mem_ready
        prev_ir = ir_out;
        fetch_start = 1'b1; pc_in = 32'h0000_0400;
        step();
        fetch_start = 1'b0;
        for (int c = 1; c < 16; c++) begin
            step();
            chk($sformatf("to_rd_%0d", c), 32'(mem_rd), 32'd1);
            chk($sformatf("to_err_%0d", c), 32'(fetch_err), 32'd0);
        end
        step();
        chk("to_abort_rd", 32'(mem_rd), 32'd0);
        chk("to_abort_err", 32'(fetch_err), 32'd1);
        chk("to_abort_busy", 32'(busy), 32'd0);
        chk("to_abort_valid", 32'(ir_valid), 32'd0);
        chk("to_abort_ir", ir_out, prev_ir);
        step();
        chk("to_sticky_err", 32'(fetch_err), 32'd1);
        fetch_start = 1'b1; pc_in = 32'h0000_0500;
        step();
        fetch_start = 1'b0;
        chk("to_clear_err", 32'(fetch_err), 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h1234_0000;
        step();
        mem_ready = 1'b0;
        chk("to_after_ir", ir_out, 32'h1234_0000);
        $display("timeout: fetch_err cleared, ir_out=0x%08h", ir_out);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
